divider_ctrl: RTL and testbench

- Issue/retire stage that sits directly in front of the unsigned iterative `divider` (XLEN-bit, vld/ack pulse handshake).
- Accepts RISC-V-style DIV/DIVU/REM/REMU requests on a valid/ready interface.
- Converts signed operands to magnitudes, drives the divider, then sign-corrects the returned quo/rem.
- Resolves divide-by-zero and signed overflow locally without issuing to the divider, and presents one result on a valid/ready response port.

---
 rtl/divider_pkg.sv | 24 ++
 rtl/div_sign_fix.sv | 29 ++
 rtl/divider_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_divider_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for divider_ctrl: op encoding, FSM state type and op-decode helpers.
package divider_pkg;

   localparam logic [1:0] OP_DIV  = 2'd0;
   localparam logic [1:0] OP_DIVU = 2'd1;
   localparam logic [1:0] OP_REM  = 2'd2;
   localparam logic [1:0] OP_REMU = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   function automatic logic is_signed_op(input logic [1:0] op);
      return !((op == OP_DIVU) || (op == OP_REMU));
   endfunction

   function automatic logic is_rem_op(input logic [1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Selects quotient or remainder for the op and restores the sign that was
// stripped before the unsigned divider.
module div_sign_fix
   import divider_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] rem,
   input  logic            sign_a,
   input  logic            sign_b,
   input  logic [1:0]      op,
   output logic [XLEN-1:0] res
);

   logic neg_q;
   logic neg_r;

   always_comb begin
      neg_q = is_signed_op(op) && (sign_a != sign_b);
      neg_r = is_signed_op(op) && sign_a;
      if (is_rem_op(op)) begin
         res = neg_r ? ('0 - rem) : rem;
      end else begin
         res = neg_q ? ('0 - quo) : quo;
      end
   end

endmodule

// File: rtl/divider_ctrl.sv
// Issue/retire stage in front of the unsigned iterative divider.
// Optional DIVIDER_CTRL_REUSE_EN keeps the last quo/rem pair to answer the DIV<->REM twin.
module divider_ctrl
   import divider_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_vld,
   output logic            req_rdy,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_vld,
   input  logic            resp_rdy,
   output logic [XLEN-1:0] resp_data,
   output logic            div_vld,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   input  logic            div_ack,
   input  logic [XLEN-1:0] div_quo,
   input  logic [XLEN-1:0] div_rem
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   state_t          state_nx;
   logic [1:0]      op_r;
   logic            sa_r;
   logic            sb_r;
   logic            acc;
   logic            req_sgn;
   logic            div_zero;
   logic            ovf;
   logic            special;
   logic            reuse_hit;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] fix_quo;
   logic [XLEN-1:0] fix_rem;
   logic            fix_sa;
   logic            fix_sb;
   logic [1:0]      fix_op;
   logic [XLEN-1:0] fix_res;

   always_comb begin
      req_sgn  = is_signed_op(req_op);
      mag_a    = (req_sgn && req_a[XLEN-1]) ? ('0 - req_a) : req_a;
      mag_b    = (req_sgn && req_b[XLEN-1]) ? ('0 - req_b) : req_b;
      div_zero = (req_b == '0);
      ovf      = req_sgn && (req_a == MIN_NEG) && (req_b == '1);
      special  = div_zero || ovf;
      if (div_zero) begin
         special_res = is_rem_op(req_op) ? req_a : '1;
      end else begin
         special_res = is_rem_op(req_op) ? '0 : req_a;
      end
   end

   assign acc = req_vld && req_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (acc) state_nx = (special || reuse_hit) ? S_RESP : S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (div_ack) state_nx = S_RESP;
         S_RESP:  if (resp_rdy) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req_rdy  = (state == S_IDLE) && !rst;
      resp_vld = (state == S_RESP) && !rst;
      div_vld  = (state == S_ISSUE) && !rst;
   end

`ifdef DIVIDER_CTRL_REUSE_EN
   logic [XLEN-1:0] st_quo;
   logic [XLEN-1:0] st_rem;
   logic [XLEN-1:0] st_a;
   logic [XLEN-1:0] st_b;
   logic            st_sgn;
   logic            st_rem_op;
   logic            st_vld;

   // Key is captured at issue and only marked valid once the divider answers,
   // so an aborted operation can never be reused.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_quo    <= '0;
         st_rem    <= '0;
         st_a      <= '0;
         st_b      <= '0;
         st_sgn    <= 1'b0;
         st_rem_op <= 1'b0;
         st_vld    <= 1'b0;
      end else if (acc && !special && !reuse_hit) begin
         st_a      <= req_a;
         st_b      <= req_b;
         st_sgn    <= req_sgn;
         st_rem_op <= is_rem_op(req_op);
         st_vld    <= 1'b0;
      end else if ((state == S_WAIT) && div_ack) begin
         st_quo <= div_quo;
         st_rem <= div_rem;
         st_vld <= 1'b1;
      end
   end

   assign reuse_hit = st_vld && (req_a == st_a) && (req_b == st_b) &&
                      (req_sgn == st_sgn) && (is_rem_op(req_op) != st_rem_op);

   always_comb begin
      if (state == S_IDLE) begin
         fix_quo = st_quo;
         fix_rem = st_rem;
         fix_sa  = req_a[XLEN-1];
         fix_sb  = req_b[XLEN-1];
         fix_op  = req_op;
      end else begin
         fix_quo = div_quo;
         fix_rem = div_rem;
         fix_sa  = sa_r;
         fix_sb  = sb_r;
         fix_op  = op_r;
      end
   end
`else
   assign reuse_hit = 1'b0;

   always_comb begin
      fix_quo = div_quo;
      fix_rem = div_rem;
      fix_sa  = sa_r;
      fix_sb  = sb_r;
      fix_op  = op_r;
   end
`endif

   div_sign_fix #(
      .XLEN(XLEN)
   ) u_sign_fix (
      .quo   (fix_quo),
      .rem   (fix_rem),
      .sign_a(fix_sa),
      .sign_b(fix_sb),
      .op    (fix_op),
      .res   (fix_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= '0;
         sa_r      <= 1'b0;
         sb_r      <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
         resp_data <= '0;
      end else begin
         if (acc) begin
            op_r <= req_op;
            sa_r <= req_a[XLEN-1];
            sb_r <= req_b[XLEN-1];
            if (special) begin
               resp_data <= special_res;
            end else if (reuse_hit) begin
               resp_data <= fix_res;
            end else begin
               div_a <= mag_a;
               div_b <= mag_b;
            end
         end
         if ((state == S_WAIT) && div_ack) begin
            resp_data <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl with a behavioural divider and reference model.
module tb_divider_ctrl;

   localparam logic [1:0] DIV  = 2'd0;
   localparam logic [1:0] DIVU = 2'd1;
   localparam logic [1:0] REM  = 2'd2;
   localparam logic [1:0] REMU = 2'd3;
`ifdef DIVIDER_CTRL_REUSE_EN
   localparam bit REUSE_ON = 1'b1;
`else
   localparam bit REUSE_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_vld = 1'b0;
   logic        req_rdy;
   logic [1:0]  req_op = 2'd0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        resp_vld;
   logic        resp_rdy = 1'b1;
   logic [31:0] resp_data;
   logic        div_vld;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_ack;
   logic [31:0] div_quo;
   logic [31:0] div_rem;

   divider_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data),
      .div_vld(div_vld), .div_a(div_a), .div_b(div_b),
      .div_ack(div_ack), .div_quo(div_quo), .div_rem(div_rem)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the architectural values.
   function automatic logic is_sgn(input logic [1:0] op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (is_sgn(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      if (b == 0) return ((op == DIV) || (op == DIVU)) ? 32'hFFFF_FFFF : a;
      if (is_sgn(op)) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'b0, a});
         y = longint'({32'b0, b});
      end
      return ((op == DIV) || (op == DIVU)) ? 32'(x / y) : 32'(x % y);
   endfunction

   function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] v);
      longint x;
      if (!is_sgn(op)) return v;
      x = longint'($signed(v));
      if (x < 0) x = -x;
      return 32'(x);
   endfunction

   logic        ru_vld = 1'b0;
   logic [31:0] ru_a = '0;
   logic [31:0] ru_b = '0;
   logic        ru_sgn = 1'b0;
   logic        ru_rem = 1'b0;

   function automatic logic reuse_match(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return ru_vld && (a == ru_a) && (b == ru_b) && (is_sgn(op) == ru_sgn) &&
             (((op == REM) || (op == REMU)) != ru_rem);
   endfunction

   // Behavioural divider: acks 1..5 cycles after div_vld (or fixed_lat), computing from held div_a/div_b.
   int          fixed_lat = 0;
   bit          stray_req = 1'b0;
   int          div_pulses = 0;
   logic [31:0] seen_a = '0;
   logic [31:0] seen_b = '0;
   int unsigned vld_cyc = 0;
   int unsigned ack_cyc = 0;

   initial begin
      int cnt;
      cnt = 0;
      div_ack = 1'b0;
      div_quo = '0;
      div_rem = '0;
      forever begin
         @(posedge clk); #1;
         div_ack = 1'b0;
         div_quo = $urandom;
         div_rem = $urandom;
         if (rst) begin
            cnt = 0;
         end else if (div_vld) begin
            div_pulses++;
            seen_a  = div_a;
            seen_b  = div_b;
            vld_cyc = cyc;
            cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               div_ack = 1'b1;
               div_quo = (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
               div_rem = (div_b == 0) ? div_a : div_a % div_b;
               ack_cyc = cyc;
            end
         end else if (stray_req) begin
            stray_req = 1'b0;
            div_ack = 1'b1;
         end
      end
   end

   task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int bp);
      int          n;
      int          p0;
      int unsigned acc_cyc;
      logic        sp;
      logic        iss;
      logic [31:0] held;
      sp  = is_special(op, a, b);
      iss = !sp && !(REUSE_ON && reuse_match(op, a, b));
      resp_rdy = (bp == 0);
      n = 0;
      while (!req_rdy && n < 20) begin @(posedge clk); #1; n++; end
      chk({name, "/req_rdy"}, 32'(req_rdy), 32'd1);
      p0 = div_pulses;
      req_vld = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clk); #1;
      acc_cyc = cyc;
      req_vld = 1'b0; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
      n = 0;
      while (!resp_vld && n < 60) begin @(posedge clk); #1; n++; end
      chk({name, "/resp_vld"}, 32'(resp_vld), 32'd1);
      chk({name, "/data"}, resp_data, exp);
      chk({name, "/div_pulses"}, 32'(div_pulses - p0), iss ? 32'd1 : 32'd0);
      if (iss) begin
         chk({name, "/div_a"}, seen_a, ref_mag(op, a));
         chk({name, "/div_b"}, seen_b, ref_mag(op, b));
         chk({name, "/issue_cycle"}, vld_cyc, acc_cyc);
         chk({name, "/resp_cycle"}, cyc, ack_cyc + 1);
         ru_vld = 1'b1; ru_a = a; ru_b = b; ru_sgn = is_sgn(op);
         ru_rem = (op == REM) || (op == REMU);
      end else begin
         chk({name, "/fast_latency"}, 32'(n), 32'd0);
      end
      if (bp > 0) begin
         held = resp_data;
         req_vld = 1'b1; req_op = DIVU; req_a = 32'd5; req_b = 32'd0;
         for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({name, "/hold_vld"}, 32'(resp_vld), 32'd1);
            chk({name, "/hold_data"}, resp_data, held);
            chk({name, "/hold_rdy"}, 32'(req_rdy), 32'd0);
         end
         req_vld = 1'b0;
         resp_rdy = 1'b1;
      end
      @(posedge clk); #1;
      chk({name, "/done_vld"}, 32'(resp_vld), 32'd0);
      chk({name, "/done_rdy"}, 32'(req_rdy), 32'd1);
      if (bp > 0) begin
         repeat (2) begin @(posedge clk); #1; end
         chk({name, "/no_accept"}, 32'(resp_vld), 32'd0);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int          n;
      int          p;
      logic        seen;
      logic [1:0]  op, pop;
      logic [31:0] a, b, pa, pb;
      int          bp;

      vecs = '{
         '{DIVU, 32'd10,         32'd7,         32'd1},
         '{REMU, 32'd10,         32'd7,         32'd3},
         '{DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2},
         '{REM,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE},
         '{REM,  32'd100,        32'hFFFF_FFF9, 32'd2},
         '{DIVU, 32'd100,        32'd0,         32'hFFFF_FFFF},
         '{REMU, 32'd100,        32'd0,         32'd100},
         '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
         '{REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
         '{DIV,  32'd7,          32'd0,         32'hFFFF_FFFF},
         '{REM,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB},
         '{DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3},
         '{REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF},
         '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
         '{DIV,  32'h8000_0000,  32'd1,         32'h8000_0000}
      };

      repeat (2) @(posedge clk);
      #1;
      chk("reset/req_rdy", 32'(req_rdy), 32'd0);
      chk("reset/resp_vld", 32'(resp_vld), 32'd0);
      chk("reset/resp_data", resp_data, 32'd0);
      chk("reset/div_vld", 32'(div_vld), 32'd0);
      chk("reset/div_a", div_a, 32'd0);
      chk("reset/div_b", div_b, 32'd0);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("reset/idle_rdy", 32'(req_rdy), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
      end

      run_req("backpressure", DIVU, 32'd1000, 32'd10, 32'd100, 5);

      fixed_lat = 12;
      resp_rdy = 1'b1;
      req_vld = 1'b1; req_op = DIVU; req_a = 32'd50; req_b = 32'd5;
      @(posedge clk); #1;
      req_vld = 1'b0;
      n = 0;
      while (!div_vld && n < 10) begin @(posedge clk); #1; n++; end
      chk("rstwait/div_vld", 32'(div_vld), 32'd1);
      repeat (2) begin @(posedge clk); #1; end
      chk("rstwait/in_wait_rdy", 32'(req_rdy), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      ru_vld = 1'b0;
      #1;
      chk("rstwait/req_rdy", 32'(req_rdy), 32'd1);
      chk("rstwait/resp_vld", 32'(resp_vld), 32'd0);
      chk("rstwait/resp_data", resp_data, 32'd0);
      chk("rstwait/div_a", div_a, 32'd0);
      chk("rstwait/div_vld", 32'(div_vld), 32'd0);
      fixed_lat = 0;
      stray_req = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; seen |= resp_vld; end
      chk("stray_ack/no_resp", 32'(seen), 32'd0);

      p = div_pulses;
      run_req("reuse_divu", DIVU, 32'd70, 32'd150, 32'd0, 0);
      run_req("reuse_remu", REMU, 32'd70, 32'd150, 32'd70, 0);
      chk("reuse/pulses", 32'(div_pulses - p), REUSE_ON ? 32'd1 : 32'd2);

      pa = 32'd1; pb = 32'd1; pop = DIV;
      for (int i = 0; i < 150; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin
               a = $urandom_range(0, 200);
               b = $urandom_range(1, 20);
               if ($urandom_range(0, 1) == 1) a = -a;
               if ($urandom_range(0, 1) == 1) b = -b;
            end
            1: begin a = $urandom; b = 32'd0; end
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: begin a = $urandom; b = $urandom; end
            4: begin a = pa; b = pb; op = pop ^ 2'b10; end
            default: begin a = $urandom; b = $urandom_range(1, 9); end
         endcase
         bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_req($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b), bp);
         pa = a; pb = b; pop = op;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
